// File: rtl/maxi_seq_pkg.sv
// Shared types and fixed AXI attribute constants for the memory sequencer.
package maxi_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    localparam int         ID_W      = 4;
    localparam logic [7:0] AXI_LEN   = 8'd0;
    localparam logic [2:0] AXI_SIZE  = 3'd2;
    localparam logic [1:0] AXI_BURST = 2'b01;
    localparam logic [3:0] AXI_CACHE = 4'b0011;
    localparam logic [2:0] AXI_PROT  = 3'b010;
    localparam logic [3:0] AXI_QOS   = 4'd0;
    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/maxi_seq_if.sv
// AXI4 write/read channel bundle between the sequencer (master) and memory (slave).
interface maxi_seq_if
    import maxi_seq_pkg::*;
#(
    parameter int SAW = 32,
    parameter int SDW = 32
);
    logic [ID_W-1:0]  awid;
    logic [SAW-1:0]   awaddr;
    logic [7:0]       awlen;
    logic [2:0]       awsize;
    logic [1:0]       awburst;
    logic             awlock;
    logic [3:0]       awcache;
    logic [2:0]       awprot;
    logic [3:0]       awqos;
    logic             awvalid;
    logic             awready;

    logic [SDW-1:0]   wdata;
    logic [SDW/8-1:0] wstrb;
    logic             wlast;
    logic             wvalid;
    logic             wready;

    logic [1:0]       bresp;
    logic             bvalid;
    logic             bready;

    logic [ID_W-1:0]  arid;
    logic [SAW-1:0]   araddr;
    logic [7:0]       arlen;
    logic [2:0]       arsize;
    logic [1:0]       arburst;
    logic             arlock;
    logic [3:0]       arcache;
    logic [2:0]       arprot;
    logic [3:0]       arqos;
    logic             arvalid;
    logic             arready;

    logic [SDW-1:0]   rdata;
    logic [1:0]       rresp;
    logic             rlast;
    logic             rvalid;
    logic             rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/maxi_seq_issue.sv
// Valid/ready issuer: holds valid while enabled until NUM handshakes have completed.
module maxi_seq_issue #(
    parameter int NUM = 16,
    parameter int CW  = $clog2(NUM + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    input  logic ready_i,
    output logic valid_o,
    output logic fire_o
);
    logic [CW-1:0] cnt_q, cnt_d;

    // Valid falls as soon as the count reaches NUM, i.e. the cycle after the last handshake.
    assign valid_o = en_i && (cnt_q != CW'(NUM));
    assign fire_o  = valid_o && ready_i;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (fire_o)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/maxi_seq_ctrl.sv
// Write-then-read-back AXI memory test sequencer.
// Optional MAXI_SEQ_RESP_CHECK_EN: non-OKAY bresp/rresp also flag an error.
module maxi_seq_ctrl
    import maxi_seq_pkg::*;
#(
    parameter int             SAW  = 32,
    parameter int             SDW  = 32,
    parameter int             NUM  = 16,
    parameter logic [SAW-1:0] BASE = SAW'(32'h0000_0000)
) (
    input  logic           m_axi_aclk,
    input  logic           reset,
    input  logic           start,
    output logic           done,
    output logic           error,
    output logic [SAW-1:0] err_addr,
    maxi_seq_if.master     m_axi
);
    localparam int            CW    = $clog2(NUM + 1);
    localparam logic [CW-1:0] NUM_C = CW'(NUM);

    state_t         state_q, state_d;
    logic [SAW-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d, raddr_q, raddr_d;
    logic [SAW-1:0] err_addr_q, err_addr_d;
    logic [SDW-1:0] wdata_q, wdata_d, rexp_q, rexp_d;
    logic [CW-1:0]  bcnt_q, bcnt_d, rcnt_q, rcnt_d;
    logic           error_q, error_d;
    logic           start_acc, aw_fire, w_fire, ar_fire, b_fire, r_fire, r_bad;
    logic           unused_in;

    assign start_acc = start && (state_q == S_IDLE || state_q == S_FIN);
    assign b_fire    = m_axi.bvalid && m_axi.bready && (bcnt_q != NUM_C);
    assign r_fire    = m_axi.rvalid && m_axi.rready && (rcnt_q != NUM_C);

    maxi_seq_issue #(.NUM(NUM)) u_aw (
        .clk_i(m_axi_aclk), .rst_i(reset), .clear_i(start_acc), .en_i(state_q == S_WRITE),
        .ready_i(m_axi.awready), .valid_o(m_axi.awvalid), .fire_o(aw_fire)
    );
    maxi_seq_issue #(.NUM(NUM)) u_w (
        .clk_i(m_axi_aclk), .rst_i(reset), .clear_i(start_acc), .en_i(state_q == S_WRITE),
        .ready_i(m_axi.wready), .valid_o(m_axi.wvalid), .fire_o(w_fire)
    );
    maxi_seq_issue #(.NUM(NUM)) u_ar (
        .clk_i(m_axi_aclk), .rst_i(reset), .clear_i(start_acc), .en_i(state_q == S_READ),
        .ready_i(m_axi.arready), .valid_o(m_axi.arvalid), .fire_o(ar_fire)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_FIN: if (start)            state_d = S_WRITE;
            S_WRITE:       if (bcnt_q == NUM_C)  state_d = S_READ;
            S_READ:        if (rcnt_q == NUM_C)  state_d = S_FIN;
            default:                             state_d = S_IDLE;
        endcase
    end

`ifdef MAXI_SEQ_RESP_CHECK_EN
    logic [SAW-1:0] baddr_q, baddr_d;
    assign r_bad     = (m_axi.rdata != rexp_q) || (m_axi.rresp != RESP_OKAY);
    assign unused_in = m_axi.rlast;
`else
    assign r_bad     = (m_axi.rdata != rexp_q);
    assign unused_in = ^{m_axi.rlast, m_axi.bresp, m_axi.rresp};
`endif

    always_comb begin
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        araddr_d   = araddr_q;
        raddr_d    = raddr_q;
        rexp_d     = rexp_q;
        bcnt_d     = bcnt_q;
        rcnt_d     = rcnt_q;
        error_d    = error_q;
        err_addr_d = err_addr_q;
`ifdef MAXI_SEQ_RESP_CHECK_EN
        baddr_d    = baddr_q;
`endif
        if (start_acc) begin
            awaddr_d   = BASE;
            wdata_d    = {SDW{1'b1}};
            araddr_d   = BASE;
            raddr_d    = BASE;
            rexp_d     = {SDW{1'b1}};
            bcnt_d     = '0;
            rcnt_d     = '0;
            error_d    = 1'b0;
            err_addr_d = '0;
`ifdef MAXI_SEQ_RESP_CHECK_EN
            baddr_d    = BASE;
`endif
        end else begin
            if (aw_fire) awaddr_d = awaddr_q + SAW'(4);
            if (w_fire)  wdata_d  = wdata_q - SDW'(1);
            if (ar_fire) araddr_d = araddr_q + SAW'(4);
            if (b_fire) begin
                bcnt_d = bcnt_q + CW'(1);
`ifdef MAXI_SEQ_RESP_CHECK_EN
                baddr_d = baddr_q + SAW'(4);
                if (m_axi.bresp != RESP_OKAY && !error_q) begin
                    error_d    = 1'b1;
                    err_addr_d = baddr_q;
                end
`endif
            end
            // R beats arrive in issue order, so a running expected word/address suffices.
            if (r_fire) begin
                rcnt_d  = rcnt_q + CW'(1);
                rexp_d  = rexp_q - SDW'(1);
                raddr_d = raddr_q + SAW'(4);
                if (r_bad && !error_q) begin
                    error_d    = 1'b1;
                    err_addr_d = raddr_q;
                end
            end
        end
    end

    always_ff @(posedge m_axi_aclk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            awaddr_q   <= '0;
            wdata_q    <= {SDW{1'b1}};
            araddr_q   <= '0;
            raddr_q    <= '0;
            rexp_q     <= {SDW{1'b1}};
            bcnt_q     <= '0;
            rcnt_q     <= '0;
            error_q    <= 1'b0;
            err_addr_q <= '0;
`ifdef MAXI_SEQ_RESP_CHECK_EN
            baddr_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            araddr_q   <= araddr_d;
            raddr_q    <= raddr_d;
            rexp_q     <= rexp_d;
            bcnt_q     <= bcnt_d;
            rcnt_q     <= rcnt_d;
            error_q    <= error_d;
            err_addr_q <= err_addr_d;
`ifdef MAXI_SEQ_RESP_CHECK_EN
            baddr_q    <= baddr_d;
`endif
        end
    end

    assign done     = (state_q == S_FIN);
    assign error    = error_q;
    assign err_addr = err_addr_q;

    assign m_axi.awid    = '0;
    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awlen   = AXI_LEN;
    assign m_axi.awsize  = AXI_SIZE;
    assign m_axi.awburst = AXI_BURST;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awcache = AXI_CACHE;
    assign m_axi.awprot  = AXI_PROT;
    assign m_axi.awqos   = AXI_QOS;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = '1;
    assign m_axi.wlast   = 1'b1;
    assign m_axi.bready  = (state_q == S_WRITE);
    assign m_axi.arid    = '0;
    assign m_axi.araddr  = araddr_q;
    assign m_axi.arlen   = AXI_LEN;
    assign m_axi.arsize  = AXI_SIZE;
    assign m_axi.arburst = AXI_BURST;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = AXI_CACHE;
    assign m_axi.arprot  = AXI_PROT;
    assign m_axi.arqos   = AXI_QOS;
    assign m_axi.rready  = (state_q == S_READ);

endmodule

// File: tb/tb_maxi_seq_ctrl.sv
// Self-checking bench for maxi_seq_ctrl: echo memory slave plus expected-beat scoreboard.
module tb_maxi_seq_ctrl;
    localparam int SAW = 32;
    localparam int SDW = 32;
    localparam int NUM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        done, error;
    logic [31:0] err_addr;

    maxi_seq_if #(.SAW(SAW), .SDW(SDW)) bus ();

    maxi_seq_ctrl #(.SAW(SAW), .SDW(SDW), .NUM(NUM), .BASE(32'h0000_0000)) dut (
        .m_axi_aclk(clk), .reset(rst), .start(start), .done(done),
        .error(error), .err_addr(err_addr), .m_axi(bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_aw[$], exp_w[$], exp_ar[$];
    logic [31:0] awq[$], wq[$], rq[$];
    logic [1:0]  bq[$];
    logic [31:0] mem [logic [31:0]];
    bit          corrupt [logic [31:0]];
    logic [31:0] bad_b_addr = 32'hFFFF_FFFF;
    int          aw_stall = 0;
    int          b_seen = 0;
    bit          ar_started = 1'b0;
    bit          aw_hold = 1'b0;
    logic [31:0] aw_held;

    // Memory slave and scoreboard: outputs set at negedge, handshakes judged with the
    // values that will be present at the following posedge.
    initial begin
        bus.awready = 0; bus.wready = 0; bus.arready = 0;
        bus.bvalid = 0; bus.bresp = 0; bus.rvalid = 0; bus.rdata = 0;
        bus.rresp = 0; bus.rlast = 1;
        forever begin
            @(negedge clk);
            if (rst) begin
                awq.delete(); wq.delete(); bq.delete(); rq.delete();
                exp_aw.delete(); exp_w.delete(); exp_ar.delete();
                bus.bvalid = 0; bus.rvalid = 0; aw_hold = 0;
                continue;
            end
            bus.awready = (aw_stall == 0);
            bus.wready  = 1;
            bus.arready = 1;
            bus.bvalid  = (bq.size() > 0);
            bus.bresp   = (bq.size() > 0) ? bq[0] : 2'b00;
            bus.rvalid  = (rq.size() > 0);
            bus.rdata   = (rq.size() > 0) ? rq[0] : 32'h0;
            bus.rresp   = 2'b00;
            bus.rlast   = 1'b1;
            if (aw_hold) begin
                n_checks++;
                if (bus.awvalid !== 1'b1 || bus.awaddr !== aw_held) begin
                    n_fail++;
                    $display("FAIL aw_stable: awvalid=%b awaddr=%h, required 1/%h", bus.awvalid, bus.awaddr, aw_held);
                end
            end
            if (aw_stall > 0 && bus.awvalid) aw_stall--;
            aw_hold = bus.awvalid && !bus.awready;
            aw_held = bus.awaddr;
            if (bus.awvalid && bus.awready) begin
                n_checks++;
                if (exp_aw.size() == 0) begin
                    n_fail++; $display("FAIL aw_extra: awaddr=%h, required no beat", bus.awaddr);
                end else if (bus.awaddr !== exp_aw[0]) begin
                    n_fail++; $display("FAIL awaddr: got %h, required %h", bus.awaddr, exp_aw[0]);
                end
                if (exp_aw.size() > 0) void'(exp_aw.pop_front());
                awq.push_back(bus.awaddr);
            end
            if (bus.wvalid && bus.wready) begin
                n_checks++;
                if (exp_w.size() == 0) begin
                    n_fail++; $display("FAIL w_extra: wdata=%h, required no beat", bus.wdata);
                end else if (bus.wdata !== exp_w[0] || bus.wstrb !== 4'hF || bus.wlast !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wbeat: wdata=%h wstrb=%h wlast=%b, required %h/F/1", bus.wdata, bus.wstrb, bus.wlast, exp_w[0]);
                end
                if (exp_w.size() > 0) void'(exp_w.pop_front());
                wq.push_back(bus.wdata);
            end
            while (awq.size() > 0 && wq.size() > 0) begin
                logic [31:0] a;
                a = awq.pop_front();
                mem[a] = wq.pop_front();
                bq.push_back((a == bad_b_addr) ? 2'b10 : 2'b00);
            end
            if (bus.bvalid && bus.bready) begin
                void'(bq.pop_front());
                b_seen++;
            end
            if (bus.arvalid && bus.arready) begin
                logic [31:0] a;
                a = bus.araddr;
                if (!ar_started) begin
                    ar_started = 1;
                    n_checks++;
                    if (b_seen !== NUM) begin
                        n_fail++; $display("FAIL b_before_ar: B count %0d at first AR, required %0d", b_seen, NUM);
                    end
                end
                n_checks++;
                if (exp_ar.size() == 0) begin
                    n_fail++; $display("FAIL ar_extra: araddr=%h, required no beat", a);
                end else if (a !== exp_ar[0]) begin
                    n_fail++; $display("FAIL araddr: got %h, required %h", a, exp_ar[0]);
                end
                if (exp_ar.size() > 0) void'(exp_ar.pop_front());
                rq.push_back(corrupt.exists(a) ? 32'h0 : (mem.exists(a) ? mem[a] : 32'hDEAD_BEEF));
            end
            if (bus.rvalid && bus.rready) void'(rq.pop_front());
        end
    end

    task automatic push_pass();
        for (int i = 0; i < NUM; i++) begin
            exp_aw.push_back(32'(i * 4));
            exp_w.push_back(32'hFFFF_FFFF - 32'(i));
            exp_ar.push_back(32'(i * 4));
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1; b_seen = 0; ar_started = 0;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 300 && !done; i++) @(negedge clk);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++; $display("FAIL %s_timeout: done=%b, required 1", name, done);
        end
    endtask

    task automatic run_pass(input string name, input logic exp_err, input logic [31:0] exp_ea);
        push_pass();
        pulse_start();
        wait_done(name);
        n_checks++;
        if (error !== exp_err || err_addr !== exp_ea) begin
            n_fail++;
            $display("FAIL %s_result: error=%b err_addr=%h, required %b/%h", name, error, err_addr, exp_err, exp_ea);
        end
        n_checks++;
        if (exp_aw.size() + exp_w.size() + exp_ar.size() != 0) begin
            n_fail++;
            $display("FAIL %s_beats: %0d/%0d/%0d beats missing, required 0", name, exp_aw.size(), exp_w.size(), exp_ar.size());
        end
    endtask

    task automatic check_reset_vals(input string name);
        n_checks++;
        if (done !== 0 || error !== 0 || err_addr !== 0 || bus.awvalid !== 0 || bus.wvalid !== 0 ||
            bus.arvalid !== 0 || bus.bready !== 0 || bus.rready !== 0) begin
            n_fail++;
            $display("FAIL %s_ctrl: done=%b error=%b err_addr=%h awv=%b wv=%b arv=%b bready=%b rready=%b, required all 0",
                     name, done, error, err_addr, bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready);
        end
        n_checks++;
        if (bus.wdata !== 32'hFFFF_FFFF || bus.awaddr !== 0 || bus.araddr !== 0) begin
            n_fail++;
            $display("FAIL %s_data: wdata=%h awaddr=%h araddr=%h, required FFFFFFFF/0/0", name, bus.wdata, bus.awaddr, bus.araddr);
        end
    endtask

    task automatic test_reset();
        rst = 1; start = 0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        n_checks++;
        if (bus.awsize !== 3'd2 || bus.awburst !== 2'b01 || bus.awcache !== 4'b0011 || bus.awprot !== 3'b010 ||
            bus.arsize !== 3'd2 || bus.arburst !== 2'b01 || bus.arcache !== 4'b0011 || bus.arprot !== 3'b010 ||
            bus.awlen !== 0 || bus.arlen !== 0 || bus.awid !== 0 || bus.arid !== 0 || bus.awlock !== 0 || bus.awqos !== 0) begin
            n_fail++;
            $display("FAIL attrs: awsize=%0d awburst=%0d awcache=%h awprot=%0d, required 2/1/3/2", bus.awsize, bus.awburst, bus.awcache, bus.awprot);
        end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_pass("basic", 1'b0, 32'h0);
    endtask

    task automatic test_aw_stall();
        aw_stall = 5;
        run_pass("aw_stall", 1'b0, 32'h0);
        n_checks++;
        if (aw_stall !== 0) begin
            n_fail++; $display("FAIL aw_stall_used: stall remaining %0d, required 0", aw_stall);
        end
    endtask

    task automatic test_read_corrupt();
        corrupt[32'h8] = 1; corrupt[32'hC] = 1;
        run_pass("corrupt", 1'b1, 32'h8);
        corrupt.delete();
    endtask

    task automatic test_reset_mid_read();
        corrupt[32'h0] = 1;
        push_pass();
        pulse_start();
        for (int i = 0; i < 300 && !(error && bus.rready); i++) @(negedge clk);
        n_checks++;
        if (error !== 1'b1 || bus.rready !== 1'b1) begin
            n_fail++; $display("FAIL midread_reach: error=%b rready=%b, required 1/1", error, bus.rready);
        end
        rst = 1;
        @(negedge clk);
        check_reset_vals("midread");
        rst = 0;
        corrupt.delete();
        @(negedge clk);
        run_pass("after_reset", 1'b0, 32'h0);
    endtask

    task automatic test_resp_error();
        bad_b_addr = 32'h4;
`ifdef MAXI_SEQ_RESP_CHECK_EN
        run_pass("bresp", 1'b1, 32'h4);
`else
        run_pass("bresp", 1'b0, 32'h0);
`endif
        bad_b_addr = 32'hFFFF_FFFF;
    endtask

    task automatic test_start_handling();
        corrupt[32'h4] = 1;
        push_pass();
        pulse_start();
        n_checks++;
        if (bus.awvalid !== 1'b1) begin
            n_fail++; $display("FAIL write_entry: awvalid=%b, required 1", bus.awvalid);
        end
        start = 1;
        @(negedge clk);
        start = 0;
        wait_done("ignored_start");
        n_checks++;
        if (error !== 1'b1 || err_addr !== 32'h4 || exp_aw.size() + exp_w.size() + exp_ar.size() != 0) begin
            n_fail++;
            $display("FAIL ignored_start: error=%b err_addr=%h pending=%0d, required 1/4/0", error, err_addr,
                     exp_aw.size() + exp_w.size() + exp_ar.size());
        end
        corrupt.delete();
        push_pass();
        pulse_start();
        n_checks++;
        if (done !== 1'b0 || error !== 1'b0 || err_addr !== 0) begin
            n_fail++; $display("FAIL fin_restart_clear: done=%b error=%b err_addr=%h, required 0/0/0", done, error, err_addr);
        end
        wait_done("second_pass");
        n_checks++;
        if (error !== 1'b0) begin
            n_fail++; $display("FAIL second_pass_error: error=%b, required 0", error);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_aw_stall();
        test_read_corrupt();
        test_reset_mid_read();
        test_resp_error();
        test_start_handling();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
